// File: rtl/hit_judge.sv
// Whack-a-mole round referee: arms on a mole request, grades the reaction time into a 3-bit score.
// Optional macro HIT_PENALTY_EN: a wrong-key press ends the round as a miss.
module hit_judge #(
  parameter logic [15:0] WINDOW_TICKS    = 16'd1500,
  parameter logic [15:0] BAND_TICKS      = 16'd300,
  parameter logic [2:0]  MAX_SCORE       = 3'd5,
  parameter logic [3:0]  COOLDOWN_CYCLES = 4'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       mole_start,
  input  logic [3:0] mole_hole,
  input  logic [8:0] keys,
  output logic       hit_success,
  output logic [2:0] round_score,
  output logic       miss,
  output logic       active,
  output logic [3:0] cur_hole
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    COOL = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] elapsed_q, elapsed_d;
  logic [8:0]  keys_q;
  logic [3:0]  cur_hole_q, cur_hole_d;
  logic [2:0]  score_q, score_d;
  logic        hit_q, hit_d;
  logic        miss_q, miss_d;
  logic [3:0]  cnt_q, cnt_d;

  logic [8:0]  key_edge;
  logic [8:0]  hole_oh;
  logic        hit_w;
  logic        wrong_w;
  logic        timeout_w;

  // Band index by comparing against multiples of BAND_TICKS; the score clamps at 1.
  function automatic logic [2:0] score_f(input logic [15:0] el);
    logic [2:0]  s;
    logic [18:0] thr;
    s = MAX_SCORE;
    for (int m = 1; m < 8; m++) begin
      thr = 19'(m) * {3'b000, BAND_TICKS};
      if (({3'b000, el} >= thr) && (s > 3'd1)) s = s - 3'd1;
    end
    return s;
  endfunction

  always_comb begin
    key_edge  = keys & ~keys_q;
    hole_oh   = 9'd1 << cur_hole_q;
    hit_w     = |(key_edge & hole_oh);
`ifdef HIT_PENALTY_EN
    wrong_w   = |(key_edge & ~hole_oh);
`else
    wrong_w   = 1'b0;
`endif
    timeout_w = (elapsed_q >= WINDOW_TICKS);
  end

  always_comb begin
    state_d    = state_q;
    elapsed_d  = elapsed_q;
    cur_hole_d = cur_hole_q;
    score_d    = score_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (mole_start && (mole_hole <= 4'd8)) begin
          cur_hole_d = mole_hole;
          elapsed_d  = 16'd0;
          state_d    = UP;
        end
      end
      UP: begin
        // Hit takes priority over timeout and wrong key; it grades the pre-tick elapsed value.
        if (hit_w) begin
          score_d = score_f(elapsed_q);
          hit_d   = 1'b1;
          cnt_d   = COOLDOWN_CYCLES;
          state_d = COOL;
        end else if (timeout_w || wrong_w) begin
          score_d = 3'd0;
          miss_d  = 1'b1;
          cnt_d   = COOLDOWN_CYCLES;
          state_d = COOL;
        end else if (tick && (elapsed_q < WINDOW_TICKS)) begin
          elapsed_d = elapsed_q + 16'd1;
        end
      end
      COOL: begin
        // Strobe cycle loads the count; COOLDOWN_CYCLES further cycles elapse before IDLE.
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      elapsed_q  <= 16'd0;
      keys_q     <= 9'd0;
      cur_hole_q <= 4'd0;
      score_q    <= 3'd0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      cnt_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      elapsed_q  <= elapsed_d;
      keys_q     <= keys;
      cur_hole_q <= cur_hole_d;
      score_q    <= score_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      cnt_q      <= cnt_d;
    end
  end

  assign hit_success = hit_q;
  assign miss        = miss_q;
  assign round_score = score_q;
  assign active      = (state_q == UP);
  assign cur_hole    = cur_hole_q;

endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge: scoring bands, clamp, timeout, held keys, cooldown, reset abort.
module tb_hit_judge;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       mole_start;
  logic [3:0] mole_hole;
  logic [8:0] keys;
  logic       hit_success;
  logic [2:0] round_score;
  logic       miss;
  logic       active;
  logic [3:0] cur_hole;

  int n_checks;
  int n_errors;
  int strobes;

  hit_judge dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .mole_start  (mole_start),
    .mole_hole   (mole_hole),
    .keys        (keys),
    .hit_success (hit_success),
    .round_score (round_score),
    .miss        (miss),
    .active      (active),
    .cur_hole    (cur_hole)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_ticks(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_round(input logic [3:0] h);
    mole_start = 1'b1;
    mole_hole  = h;
    step();
    mole_start = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; tick = 1'b0; mole_start = 1'b0; mole_hole = 4'd0; keys = 9'd0;
    repeat (3) step();
    check("rst_hit", int'(hit_success), 0);
    check("rst_miss", int'(miss), 0);
    check("rst_active", int'(active), 0);
    check("rst_score", int'(round_score), 0);
    check("rst_hole", int'(cur_hole), 0);
    rst = 1'b0;
    step();

    // Round 1: hole 3, hit after 100 ticks
    start_round(4'd3);
    check("r1_active", int'(active), 1);
    check("r1_hole", int'(cur_hole), 3);
    run_ticks(100);
    keys[3] = 1'b1;
    step();
    check("r1_hit", int'(hit_success), 1);
    check("r1_score", int'(round_score), 5);
    check("r1_active_fall", int'(active), 0);
    check("r1_miss", int'(miss), 0);
    step();
    check("r1_hit_one_cycle", int'(hit_success), 0);
    keys[3] = 1'b0;
    mole_start = 1'b1; mole_hole = 4'd1;
    step();
    mole_start = 1'b0;
    check("cool_start_ignored", int'(active), 0);
    repeat (6) step();
    mole_start = 1'b1; mole_hole = 4'd0;
    step();
    check("cool_last_cycle_ignored", int'(active), 0);
    step();
    mole_start = 1'b0;
    check("idle_after_cool", int'(active), 1);
    check("idle_after_cool_hole", int'(cur_hole), 0);

    // Round 2: hole 0, hit after 650 ticks (band 2)
    run_ticks(650);
    keys[0] = 1'b1;
    step();
    check("r2_hit", int'(hit_success), 1);
    check("r2_score", int'(round_score), 3);
    keys[0] = 1'b0;
    repeat (11) step();
    check("r2_score_hold", int'(round_score), 3);

    // Round 3: hole 0, hit after 1400 ticks clamps to 1
    start_round(4'd0);
    run_ticks(1400);
    keys[0] = 1'b1;
    step();
    check("r3_hit", int'(hit_success), 1);
    check("r3_score_clamp", int'(round_score), 1);
    keys[0] = 1'b0;
    repeat (11) step();

    // Round 4: hole 8, timeout
    start_round(4'd8);
    check("r4_hole", int'(cur_hole), 8);
    strobes = 0;
    tick = 1'b1;
    repeat (1500) begin
      step();
      if (hit_success) strobes++;
    end
    check("r4_active_before_timeout", int'(active), 1);
    check("r4_no_early_miss", int'(miss), 0);
    step();
    tick = 1'b0;
    if (hit_success) strobes++;
    check("r4_miss", int'(miss), 1);
    check("r4_score_zero", int'(round_score), 0);
    check("r4_active_fall", int'(active), 0);
    check("r4_no_hit", strobes, 0);
    keys[5] = 1'b1;
    step();
    check("r4_miss_one_cycle", int'(miss), 0);
    repeat (7) step();
    mole_start = 1'b1; mole_hole = 4'd5;
    step();
    check("r4_cool_8_cycles", int'(active), 0);
    step();
    mole_start = 1'b0;
    check("r5_active", int'(active), 1);
    check("r5_hole", int'(cur_hole), 5);

    // Round 5: key5 held from before the round never scores; re-press at tick 50
    run_ticks(20);
    check("r5_held_no_hit", int'(hit_success), 0);
    check("r5_held_still_up", int'(active), 1);
    keys[5] = 1'b0;
    run_ticks(30);
    keys[5] = 1'b1;
    step();
    check("r5_hit", int'(hit_success), 1);
    check("r5_score", int'(round_score), 5);
    keys[5] = 1'b0;
    repeat (11) step();

    // Round 6: wrong key 2 while mole on hole 4
    start_round(4'd4);
    run_ticks(10);
    keys[2] = 1'b1;
    step();
`ifdef HIT_PENALTY_EN
    check("r6_wrong_miss", int'(miss), 1);
    check("r6_wrong_score", int'(round_score), 0);
    check("r6_wrong_active", int'(active), 0);
    keys[2] = 1'b0;
    repeat (11) step();
`else
    check("r6_wrong_no_miss", int'(miss), 0);
    check("r6_wrong_still_up", int'(active), 1);
    check("r6_wrong_no_hit", int'(hit_success), 0);
    keys[2] = 1'b0;
    run_ticks(289);
    tick = 1'b1;
    keys[4] = 1'b1;
    step();
    tick = 1'b0;
    check("r6_hit_with_tick", int'(hit_success), 1);
    check("r6_score_pre_increment", int'(round_score), 5);
    keys[4] = 1'b0;
    repeat (11) step();
`endif

    // Round 7: exactly one band elapsed
    start_round(4'd7);
    run_ticks(300);
    keys[7] = 1'b1;
    step();
    check("r7_hit", int'(hit_success), 1);
    check("r7_score_band1", int'(round_score), 4);
    keys[7] = 1'b0;
    repeat (11) step();

    // Round 8: hit coincides with timeout
    start_round(4'd1);
    run_ticks(1500);
    keys[1] = 1'b1;
    step();
    check("r8_hit_wins", int'(hit_success), 1);
    check("r8_no_miss", int'(miss), 0);
    check("r8_score", int'(round_score), 1);
    keys[1] = 1'b0;
    repeat (11) step();

    // Out-of-range hole ignored
    start_round(4'd9);
    check("hole9_ignored", int'(active), 0);
    check("hole9_hole_kept", int'(cur_hole), 1);

    // Reset mid-UP
    start_round(4'd2);
    run_ticks(10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_up_active", int'(active), 0);
    check("rst_up_hole", int'(cur_hole), 0);
    check("rst_up_score", int'(round_score), 0);
    strobes = 0;
    repeat (12) begin
      if (hit_success || miss) strobes++;
      step();
    end
    check("rst_up_no_strobe", strobes, 0);
    start_round(4'd6);
    check("post_rst_active", int'(active), 1);
    check("post_rst_hole", int'(cur_hole), 6);
    run_ticks(5);
    keys[6] = 1'b1;
    step();
    check("post_rst_hit", int'(hit_success), 1);
    check("post_rst_score", int'(round_score), 5);
    step();
    check("post_rst_hit_one_cycle", int'(hit_success), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
